// File: rtl/common_def.sv
// -----------------------------------------------------------------------------
// common_def
// Shared definitions for the pipeline stall controller.
//   stall_state_t : controller state encoding (RUN, MEM_WAIT, FLUSH).
//                   Encoding 2'b11 is unused and recovers to RUN.
//   PC_W          : width of program counter values.
// -----------------------------------------------------------------------------
package common_def;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } stall_state_t;

endpackage

// File: rtl/stall_sat_counter.sv
// -----------------------------------------------------------------------------
// stall_sat_counter
// Saturating up-counter. It counts one per clock while inc is high and
// sticks at all ones.
// Ports:
//   clk  in   clock (rising edge)
//   rst  in   asynchronous active-high reset, clears the count
//   inc  in   count-enable for this cycle
//   cnt  out  current count, W bits
// -----------------------------------------------------------------------------
module stall_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Stall, flush and redirect controller for a 5-stage in-order pipeline.
// Events are resolved in fixed priority: memory freeze, then redirect
// (pending or live), then load-to-use stall, then normal flow.
// A redirect that arrives during a memory freeze is parked and replayed when
// the freeze ends.
//
// Optional feature: define STALL_CTRL_PERF_CNT_EN to build the three
// performance counters. Without it, the counter ports read 0 and no counter
// flops are built.
//
// Ports:
//   clk                 in   clock
//   rst                 in   asynchronous active-high reset
//   lu_stall_req        in   load-to-use stall request (current cycle)
//   dmem_busy           in   data memory not ready, freezes whole pipe
//   redirect_valid      in   taken branch/jump pulse from EX
//   redirect_target     in   [31:0] redirect PC, qualified by redirect_valid
//   pc_en .. memwb_en   out  stage register enables
//   ifid_flush          out  load NOP into IF/ID
//   idex_bubble         out  load NOP into ID/EX
//   pc_sel_redirect     out  select pc_redirect_target as next PC
//   pc_redirect_target  out  [31:0] redirect PC (live or replayed)
//   lu_cnt/mem_cnt/flush_cnt out [CNT_W-1:0] performance counters
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
  import common_def::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_stall_req,
  input  logic             dmem_busy,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_target,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_sel_redirect,
  output logic [PC_W-1:0]  pc_redirect_target,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stall_state_t    state_reg, state_next;
  logic            pend_reg, pend_next;
  logic [PC_W-1:0] pend_target_reg, pend_target_next;
  logic            lu_applied;
  logic            redirect_applied;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      pend_reg        <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pend_reg        <= pend_next;
      pend_target_reg <= pend_target_next;
    end
  end

  always_comb begin
    state_next         = RUN;
    pend_next          = pend_reg;
    pend_target_next   = pend_target_reg;
    pc_en              = 1'b1;
    ifid_en            = 1'b1;
    idex_en            = 1'b1;
    exmem_en           = 1'b1;
    memwb_en           = 1'b1;
    ifid_flush         = 1'b0;
    idex_bubble        = 1'b0;
    pc_sel_redirect    = 1'b0;
    // A parked redirect always wins over a live one in the same cycle.
    pc_redirect_target = pend_reg ? pend_target_reg : redirect_target;
    lu_applied         = 1'b0;
    redirect_applied   = 1'b0;

    if (dmem_busy) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      state_next  = MEM_WAIT;
      // Park the redirect; a later one in the same freeze replaces it.
      if (redirect_valid) begin
        pend_next        = 1'b1;
        pend_target_next = redirect_target;
      end
    end else if (pend_reg || redirect_valid) begin
      pc_sel_redirect  = 1'b1;
      ifid_flush       = 1'b1;
      idex_bubble      = 1'b1;
      pend_next        = 1'b0;
      state_next       = FLUSH;
      redirect_applied = 1'b1;
    end else if (state_reg == FLUSH) begin
      // Squash the wrong-path instruction fetched during the redirect cycle;
      // a load-use request here refers to that squashed instruction.
      ifid_flush = 1'b1;
    end else if (lu_stall_req) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      lu_applied  = 1'b1;
    end

    // Reset holds every stage and keeps NOPs in the front stages.
    if (rst) begin
      pc_en              = 1'b0;
      ifid_en            = 1'b0;
      idex_en            = 1'b0;
      exmem_en           = 1'b0;
      memwb_en           = 1'b0;
      ifid_flush         = 1'b1;
      idex_bubble        = 1'b1;
      pc_sel_redirect    = 1'b0;
      pc_redirect_target = '0;
    end
  end

`ifdef STALL_CTRL_PERF_CNT_EN
  stall_sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lu_applied),
    .cnt (lu_cnt)
  );

  stall_sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dmem_busy),
    .cnt (mem_cnt)
  );

  stall_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_applied),
    .cnt (flush_cnt)
  );
`else
  assign lu_cnt    = '0;
  assign mem_cnt   = '0;
  assign flush_cnt = '0;

  // Event strobes only feed the counters; fold them into an unused sink.
  logic unused_events;
  assign unused_events = lu_applied ^ redirect_applied;
`endif

endmodule
